ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_pkg.sv | 16 +
 rtl/ram_arbiter.sv | 140 ++++++++++++++
 tb/tb_ram_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-master RAM port arbiter:
// lock FSM states, requester indices and byte-enable width.
package ram_arbiter_pkg;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKED0  = 2'd1,
      LOCKED1  = 2'd2
   } lock_state_e;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam int BE_W = 4;

endpackage

// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter for a single RAM port, with
// bounded bus locking for read-modify-write sequences.
// Ports: clk/rst (async high); m0_*/m1_* request side (req, we,
// addr, wdata, be, lock -> gnt, rvalid); shared rdata; ram_* drive
// RAM port A, ram_q returns its data one cycle later; lock_err is
// a sticky flag raised when a lock is forcibly released.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 30,
   parameter int DATA_W   = 32,
   parameter int LOCK_MAX = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [BE_W-1:0]   m0_be,
   input  logic              m0_lock,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [BE_W-1:0]   m1_be,
   input  logic              m1_lock,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              ram_wren,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data,
   output logic [BE_W-1:0]   ram_byteena,
   input  logic [DATA_W-1:0] ram_q,
   output logic              lock_err
);

   localparam int CNT_W = $clog2(LOCK_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

   lock_state_e      state_q, state_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rvalid0_q, rvalid0_d;
   logic             rvalid1_q, rvalid1_d;
   logic             err_q, err_d;
   logic [1:0]       inh_q, inh_d;

   logic held0;
   logic held1;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      // relock inhibit clears once the owner drops lock for a cycle
      inh_d     = inh_q & {m1_lock, m0_lock};
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      // a lock only holds while its owner keeps lock asserted
      held0     = (state_q == LOCKED0) && m0_lock;
      held1     = (state_q == LOCKED1) && m1_lock;

      unique case (1'b1)
         held0: m0_gnt = m0_req;
         held1: m1_gnt = m1_req;
         default: begin
            if (m0_req && m1_req) begin
               m0_gnt = (last_q == M1);
               m1_gnt = (last_q == M0);
            end else begin
               m0_gnt = m0_req;
               m1_gnt = m1_req;
            end
         end
      endcase

      if (m0_gnt) last_d = M0;
      if (m1_gnt) last_d = M1;

      if (held0 || held1) begin
         if (cnt_q == CNT_LAST) begin
            // owner counts as last so the waiter wins the next tie
            state_d = UNLOCKED;
            cnt_d   = '0;
            err_d   = 1'b1;
            last_d  = held1;
            if (held0) inh_d[0] = 1'b1;
            else       inh_d[1] = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         state_d = UNLOCKED;
         cnt_d   = '0;
         if (m0_gnt && m0_lock && !inh_q[0])
            state_d = LOCKED0;
         else if (m1_gnt && m1_lock && !inh_q[1])
            state_d = LOCKED1;
      end

      rvalid0_d = m0_gnt && !m0_we;
      rvalid1_d = m1_gnt && !m1_we;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= UNLOCKED;
         last_q    <= M1;
         cnt_q     <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         err_q     <= 1'b0;
         inh_q     <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
         err_q     <= err_d;
         inh_q     <= inh_d;
      end
   end

   assign ram_wren    = (m0_gnt && m0_we) || (m1_gnt && m1_we);
   assign ram_address = m1_gnt ? m1_addr  : m0_addr;
   assign ram_data    = m1_gnt ? m1_wdata : m0_wdata;
   assign ram_byteena = m0_gnt ? m0_be : (m1_gnt ? m1_be : '0);

   assign m0_rvalid = rvalid0_q;
   assign m1_rvalid = rvalid1_q;
   assign rdata     = ram_q;
   assign lock_err  = err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized self-checking bench for ram_arbiter: a queue-free
// behavioural model plus directed scenarios with literal checks.
module tb_ram_arbiter;

   localparam int AW = 30;
   localparam int DW = 32;
   localparam int LM = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m0_we, m0_lock;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata;
   logic [3:0]    m0_be;
   logic          m1_req, m1_we, m1_lock;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata;
   logic [3:0]    m1_be;
   logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic [DW-1:0] rdata;
   logic          ram_wren;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data;
   logic [3:0]    ram_byteena;
   logic [DW-1:0] ram_q;
   logic          lock_err;

   int total = 0;
   int bad   = 0;

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LOCK_MAX(LM)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_be(m0_be), .m0_lock(m0_lock),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_be(m1_be), .m1_lock(m1_lock),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
      .rdata(rdata), .ram_wren(ram_wren), .ram_address(ram_address),
      .ram_data(ram_data), .ram_byteena(ram_byteena), .ram_q(ram_q),
      .lock_err(lock_err)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_word(input int i);
      if (i == 16) return 32'hDEADBEEF;
      return 32'(i) * 32'h9E3779B1 ^ 32'h5A5A0F0F;
   endfunction

   // RAM port A: byte-masked write, registered read
   logic [DW-1:0] mem [64];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      end else if (ram_wren) begin
         for (int b = 0; b < 4; b++)
            if (ram_byteena[b])
               mem[ram_address[5:0]][8*b +: 8] <= ram_data[8*b +: 8];
      end
      ram_q <= mem[ram_address[5:0]];
   end

   // behavioural model: owner of a lock (-1 none), locked cycles seen
   int            mlock;
   int            mcnt;
   logic          mlast;
   logic [1:0]    minh;
   logic          merr;
   logic [1:0]    mpend;
   logic [DW-1:0] mrd;
   logic [DW-1:0] shadow [64];

   function automatic logic m_held();
      return (mlock == 0 && m0_lock) || (mlock == 1 && m1_lock);
   endfunction

   function automatic int exp_grant();
      if (mlock == 0 && m0_lock) return m0_req ? 0 : -1;
      if (mlock == 1 && m1_lock) return m1_req ? 1 : -1;
      if (m0_req && m1_req) return mlast ? 0 : 1;
      if (m0_req) return 0;
      if (m1_req) return 1;
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin : model_p
      int g;
      logic h;
      if (rst) begin
         mlock <= -1;
         mcnt  <= 0;
         mlast <= 1'b1;
         minh  <= '0;
         merr  <= 1'b0;
         mpend <= '0;
         mrd   <= '0;
         for (int i = 0; i < 64; i++) shadow[i] <= init_word(i);
      end else begin
         g = exp_grant();
         h = m_held();
         mpend[0] <= (g == 0) && !m0_we;
         mpend[1] <= (g == 1) && !m1_we;
         if (g == 0 && !m0_we) mrd <= shadow[m0_addr[5:0]];
         if (g == 1 && !m1_we) mrd <= shadow[m1_addr[5:0]];
         for (int b = 0; b < 4; b++) begin
            if (g == 0 && m0_we && m0_be[b])
               shadow[m0_addr[5:0]][8*b +: 8] <= m0_wdata[8*b +: 8];
            if (g == 1 && m1_we && m1_be[b])
               shadow[m1_addr[5:0]][8*b +: 8] <= m1_wdata[8*b +: 8];
         end
         if (g >= 0) mlast <= g[0];
         if (!m0_lock) minh[0] <= 1'b0;
         if (!m1_lock) minh[1] <= 1'b0;
         if (h) begin
            if (mcnt + 1 == LM) begin
               mlock <= -1;
               mcnt  <= 0;
               merr  <= 1'b1;
               mlast <= mlock[0];
               minh[mlock] <= 1'b1;
            end else begin
               mcnt <= mcnt + 1;
            end
         end else begin
            mlock <= -1;
            mcnt  <= 0;
            if (g == 0 && m0_lock && !minh[0]) mlock <= 0;
            if (g == 1 && m1_lock && !minh[1]) mlock <= 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : cmp_p
      int g;
      if (!rst) begin
         g = exp_grant();
         chk("gnt0", m0_gnt, g == 0);
         chk("gnt1", m1_gnt, g == 1);
         chk("rvalid0", m0_rvalid, mpend[0]);
         chk("rvalid1", m1_rvalid, mpend[1]);
         chk("lock_err", lock_err, merr);
         if (g == 0) begin
            chk("wren", ram_wren, m0_we);
            chk("addr", ram_address, m0_addr);
            chk("be", ram_byteena, m0_be);
            if (m0_we) chk("wdata", ram_data, m0_wdata);
         end else if (g == 1) begin
            chk("wren", ram_wren, m1_we);
            chk("addr", ram_address, m1_addr);
            chk("be", ram_byteena, m1_be);
            if (m1_we) chk("wdata", ram_data, m1_wdata);
         end else begin
            chk("wren_idle", ram_wren, 1'b0);
            chk("be_idle", ram_byteena, 4'b0000);
         end
         if (mpend != 2'b00) chk("rdata", rdata, mrd);
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0;
      m0_wdata = '0; m0_be = '0;
      m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0;
      m1_wdata = '0; m1_be = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      smp();
      chk("rst_err", lock_err, 1'b0);
      chk("rst_rv0", m0_rvalid, 1'b0);
      chk("rst_rv1", m1_rvalid, 1'b0);
      nxt();

      // alternating ties, m0 first after reset
      m0_req = 1; m1_req = 1;
      m0_addr = 30'h21; m1_addr = 30'h22;
      for (int i = 0; i < 6; i++) begin
         smp();
         chk("rr_m0", m0_gnt, (i % 2) == 0);
         chk("rr_m1", m1_gnt, (i % 2) == 1);
         nxt();
      end
      m0_req = 0; m1_req = 0;
      nxt();

      // single read
      m0_req = 1; m0_addr = 30'h10;
      smp();
      chk("rd_gnt", m0_gnt, 1'b1);
      chk("rd_addr", ram_address, 30'h10);
      nxt();
      m0_req = 0;
      smp();
      chk("rd_rvalid", m0_rvalid, 1'b1);
      chk("rd_data", rdata, 32'hDEADBEEF);
      nxt();

      // byte write
      m1_req = 1; m1_we = 1; m1_be = 4'b0010;
      m1_wdata = 32'h0000AB00; m1_addr = 30'h5;
      smp();
      chk("wr_wren", ram_wren, 1'b1);
      chk("wr_be", ram_byteena, 4'b0010);
      chk("wr_data", ram_data, 32'h0000AB00);
      nxt();
      m1_req = 0; m1_we = 0; m1_be = 0;
      smp();
      chk("wr_norv", m1_rvalid, 1'b0);
      nxt();

      // short lock
      m0_req = 1; m0_lock = 1;
      smp();
      chk("lk_gnt0", m0_gnt, 1'b1);
      nxt();
      m1_req = 1;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("lk_mask", m1_gnt, 1'b0);
         nxt();
      end
      m0_lock = 0; m0_req = 0;
      smp();
      chk("lk_drop", m1_gnt, 1'b1);
      nxt();
      m1_req = 0;
      nxt();

      // lock held past the limit
      m0_req = 1; m0_lock = 1;
      smp();
      chk("fr_gnt0", m0_gnt, 1'b1);
      nxt();
      m1_req = 1;
      for (int i = 1; i <= 16; i++) begin
         smp();
         chk("fr_mask", m1_gnt, 1'b0);
         nxt();
      end
      smp();
      chk("fr_m1", m1_gnt, 1'b1);
      chk("fr_err", lock_err, 1'b1);
      nxt();
      smp();
      chk("fr_tie0", m0_gnt, 1'b1);
      nxt();
      smp();
      chk("fr_norelock", m1_gnt, 1'b1);
      nxt();
      m0_req = 0; m0_lock = 0; m1_req = 0;
      smp();
      chk("fr_sticky", lock_err, 1'b1);
      nxt();

      // reset during a read
      m0_req = 1; m0_we = 0; m0_addr = 30'h3;
      rst = 1'b1;
      #1;
      chk("rs_err", lock_err, 1'b0);
      chk("rs_rv", m0_rvalid, 1'b0);
      nxt();
      rst = 1'b0; m0_req = 0;
      smp();
      chk("rs_norv", m0_rvalid, 1'b0);
      nxt();
      m0_req = 1; m1_req = 1;
      smp();
      chk("rs_tie0", m0_gnt, 1'b1);
      chk("rs_tie1", m1_gnt, 1'b0);
      nxt();
      m0_req = 0; m1_req = 0;

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         nxt();
         m0_req   = ($urandom_range(0, 9) < 7);
         m1_req   = ($urandom_range(0, 9) < 7);
         m0_we    = $urandom_range(0, 1);
         m1_we    = $urandom_range(0, 1);
         m0_addr  = AW'($urandom);
         m1_addr  = AW'($urandom);
         m0_wdata = $urandom;
         m1_wdata = $urandom;
         m0_be    = 4'($urandom);
         m1_be    = 4'($urandom);
         if ($urandom_range(0, 11) == 0) m0_lock = ~m0_lock;
         if ($urandom_range(0, 11) == 0) m1_lock = ~m1_lock;
      end
      nxt();
      m0_req = 0; m1_req = 0;
      nxt();
      nxt();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
